// File: rtl/noc_packet_injector_pkg.sv
// Noc_parameters: shared NoC constants, the flit-type encoding, the head-flit
// field layout and the injector FSM state type.
//   Noc_VC_Channel : number of virtual channels at the router local port
//   Noc_ID_X/Y_Width : widths of the node coordinate fields
//   flit_type_e    : 2-bit type carried in the top bits of every flit
//   HEAD_*_OFF     : LSB positions of the head payload fields
package Noc_parameters;

    localparam int Noc_VC_Channel = 2;
    localparam int Noc_ID_X_Width = 4;
    localparam int Noc_ID_Y_Width = 4;

    typedef enum logic [1:0] {
        FLIT_BODY      = 2'b00,
        FLIT_HEAD      = 2'b01,
        FLIT_TAIL      = 2'b10,
        FLIT_HEAD_TAIL = 2'b11
    } flit_type_e;

    // Head payload, LSB first: dst_x, dst_y, src_x, src_y, len
    localparam int HEAD_DST_X_OFF = 0;
    localparam int HEAD_DST_Y_OFF = HEAD_DST_X_OFF + Noc_ID_X_Width;
    localparam int HEAD_SRC_X_OFF = HEAD_DST_Y_OFF + Noc_ID_Y_Width;
    localparam int HEAD_SRC_Y_OFF = HEAD_SRC_X_OFF + Noc_ID_X_Width;
    localparam int HEAD_LEN_OFF   = HEAD_SRC_Y_OFF + Noc_ID_Y_Width;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAD = 2'b01,
        BODY = 2'b10
    } inj_state_e;

endpackage

// File: rtl/noc_vc_lowest_select.sv
// noc_vc_lowest_select: combinational priority encoder returning the lowest
// set index of i_req.
//   i_req   : request / credit vector
//   o_idx   : index of the lowest set bit (0 when none)
//   o_found : at least one bit of i_req is set
module noc_vc_lowest_select #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan from the top down so the lowest set bit is the one that sticks
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            o_idx = i_req[i] ? IDX_W'(i) : o_idx;
        end
        o_found = |i_req;
    end

endmodule

// File: rtl/noc_packet_injector.sv
// noc_packet_injector: turns a packet request plus a payload word stream into
// head/body/tail flits on one virtual channel toward the router local port.
//   noc_clk, noc_rst_n          : clock, async active-low reset
//   id_x, id_y                  : own node coordinates (source of the packet)
//   req_valid/ready, req_dst_*, req_len : packet request channel
//   data_valid/ready, data      : payload words, one per body/tail flit
//   out_valid, out_vc, out_flit : flit register toward the router
//   out_ready                   : per-VC credit; transfer when out_ready[out_vc]
//   pkt_count                   : completed packets, wraps at 16 bits
module noc_packet_injector
    import Noc_parameters::*;
#(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = Noc_VC_Channel,
    parameter int LEN_W    = 4
) (
    input  logic                        noc_clk,
    input  logic                        noc_rst_n,
    input  logic [Noc_ID_X_Width-1:0]   id_x,
    input  logic [Noc_ID_Y_Width-1:0]   id_y,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [Noc_ID_X_Width-1:0]   req_dst_x,
    input  logic [Noc_ID_Y_Width-1:0]   req_dst_y,
    input  logic [LEN_W-1:0]            req_len,
    input  logic                        data_valid,
    output logic                        data_ready,
    input  logic [DATA_W-1:0]           data,
    output logic                        out_valid,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_vc,
    output logic [DATA_W+1:0]           out_flit,
    input  logic [CHANNELS-1:0]         out_ready,
    output logic [15:0]                 pkt_count
);

    localparam int VC_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    if (DATA_W < HEAD_LEN_OFF + LEN_W) begin : g_head_width_check
        $error("noc_packet_injector: DATA_W too small for the head fields");
    end

    inj_state_e                r_state, w_state_nxt;
    logic [Noc_ID_X_Width-1:0] r_dst_x, w_dst_x_nxt, r_src_x, w_src_x_nxt;
    logic [Noc_ID_Y_Width-1:0] r_dst_y, w_dst_y_nxt, r_src_y, w_src_y_nxt;
    logic [LEN_W-1:0]          r_len, w_len_nxt, r_cnt, w_cnt_nxt;
    logic [VC_W-1:0]           r_vc, w_vc_nxt, w_vc_sel;
    logic                      r_out_valid, w_out_valid_nxt;
    logic [DATA_W+1:0]         r_out_flit, w_out_flit_nxt;
    logic [15:0]               r_pkt_count, w_pkt_count_nxt;
    logic                      w_vc_found, w_xfer, w_is_last;
    logic                      w_req_ready, w_data_ready;
    logic [DATA_W-1:0]         w_head_payload;

    noc_vc_lowest_select #(
        .N     (CHANNELS),
        .IDX_W (VC_W)
    ) u_vc_select (
        .i_req   (out_ready),
        .o_idx   (w_vc_sel),
        .o_found (w_vc_found)
    );

    assign w_xfer    = r_out_valid && out_ready[r_vc];
    // Both TAIL (10) and HEAD_TAIL (11) have the upper type bit set
    assign w_is_last = r_out_flit[DATA_W+1];

    // Assemble the zero-padded head payload from the latched request
    always_comb begin
        w_head_payload = '0;
        w_head_payload[HEAD_DST_X_OFF +: Noc_ID_X_Width] = r_dst_x;
        w_head_payload[HEAD_DST_Y_OFF +: Noc_ID_Y_Width] = r_dst_y;
        w_head_payload[HEAD_SRC_X_OFF +: Noc_ID_X_Width] = r_src_x;
        w_head_payload[HEAD_SRC_Y_OFF +: Noc_ID_Y_Width] = r_src_y;
        w_head_payload[HEAD_LEN_OFF   +: LEN_W]          = r_len;
    end

    // Next-state, flit register and handshake logic
    always_comb begin
        w_state_nxt      = r_state;
        w_dst_x_nxt      = r_dst_x;
        w_dst_y_nxt      = r_dst_y;
        w_src_x_nxt      = r_src_x;
        w_src_y_nxt      = r_src_y;
        w_len_nxt        = r_len;
        w_cnt_nxt        = r_cnt;
        w_vc_nxt         = r_vc;
        w_out_valid_nxt  = r_out_valid;
        w_out_flit_nxt   = r_out_flit;
        w_pkt_count_nxt  = r_pkt_count;
        w_req_ready      = 1'b0;
        w_data_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_dst_x_nxt = req_dst_x;
                    w_dst_y_nxt = req_dst_y;
                    w_src_x_nxt = id_x;
                    w_src_y_nxt = id_y;
                    w_len_nxt   = req_len;
                    w_state_nxt = HEAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HEAD: begin
                if (!r_out_valid) begin
                    // VC is chosen only once, when the head is loaded
                    if (w_vc_found) begin
                        w_vc_nxt        = w_vc_sel;
                        w_out_valid_nxt = 1'b1;
                        w_cnt_nxt       = r_len;
                        if (r_len == '0) begin
                            w_out_flit_nxt = {FLIT_HEAD_TAIL, w_head_payload};
                            w_state_nxt    = HEAD;
                        end else begin
                            w_out_flit_nxt = {FLIT_HEAD, w_head_payload};
                            w_state_nxt    = BODY;
                        end
                    end else begin
                        w_state_nxt = HEAD;
                    end
                end else if (w_xfer) begin
                    // Single-flit packet just left
                    w_out_valid_nxt = 1'b0;
                    w_pkt_count_nxt = r_pkt_count + 16'd1;
                    w_state_nxt     = IDLE;
                end else begin
                    w_state_nxt = HEAD;
                end
            end
            BODY: begin
                // A word may enter when the register is free or draining now;
                // once the tail is loaded (cnt==0) no more words are taken
                w_data_ready = (r_cnt != '0) && (!r_out_valid || w_xfer);
                if (data_valid && w_data_ready) begin
                    w_out_valid_nxt = 1'b1;
                    w_cnt_nxt       = r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) begin
                        w_out_flit_nxt = {FLIT_TAIL, data};
                    end else begin
                        w_out_flit_nxt = {FLIT_BODY, data};
                    end
                end else if (w_xfer) begin
                    w_out_valid_nxt = 1'b0;
                    if (w_is_last) begin
                        w_pkt_count_nxt = r_pkt_count + 16'd1;
                        w_state_nxt     = IDLE;
                    end else begin
                        w_state_nxt = BODY;
                    end
                end else begin
                    w_state_nxt = BODY;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_state     <= IDLE;
            r_dst_x     <= '0;
            r_dst_y     <= '0;
            r_src_x     <= '0;
            r_src_y     <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_vc        <= '0;
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_pkt_count <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_dst_x     <= w_dst_x_nxt;
            r_dst_y     <= w_dst_y_nxt;
            r_src_x     <= w_src_x_nxt;
            r_src_y     <= w_src_y_nxt;
            r_len       <= w_len_nxt;
            r_cnt       <= w_cnt_nxt;
            r_vc        <= w_vc_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_flit  <= w_out_flit_nxt;
            r_pkt_count <= w_pkt_count_nxt;
        end
    end

    assign req_ready  = w_req_ready;
    assign data_ready = w_data_ready;
    assign out_valid  = r_out_valid;
    assign out_vc     = r_vc;
    assign out_flit   = r_out_flit;
    assign pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector with hand-computed flit values.
module tb_noc_packet_injector;
    import Noc_parameters::*;

    logic        noc_clk = 1'b0;
    logic        noc_rst_n;
    logic [3:0]  id_x, id_y;
    logic        req_valid, req_ready;
    logic [3:0]  req_dst_x, req_dst_y, req_len;
    logic        data_valid, data_ready;
    logic [31:0] data;
    logic        out_valid;
    logic [0:0]  out_vc;
    logic [33:0] out_flit;
    logic [1:0]  out_ready;
    logic [15:0] pkt_count;

    noc_packet_injector #(.DATA_W(32), .CHANNELS(2), .LEN_W(4)) dut (
        .noc_clk    (noc_clk),
        .noc_rst_n  (noc_rst_n),
        .id_x       (id_x),
        .id_y       (id_y),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dst_x  (req_dst_x),
        .req_dst_y  (req_dst_y),
        .req_len    (req_len),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data       (data),
        .out_valid  (out_valid),
        .out_vc     (out_vc),
        .out_flit   (out_flit),
        .out_ready  (out_ready),
        .pkt_count  (pkt_count)
    );

    always #5 noc_clk = ~noc_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [1:0]  rdy_pat [0:63];
    logic [31:0] wq [0:7];
    int          rst_at;
    logic [33:0] got_flit [0:15];
    logic [0:0]  got_vc [0:15];
    int          got_cyc [0:15];
    int          n_got, n_stall, n_hold_err, n_dr_err, n_rr_err;
    logic [15:0] exp_pkts;

    task automatic set_rdy(input int from, input int upto, input logic [1:0] v);
        for (int i = from; i <= upto; i++) rdy_pat[i] = v;
    endtask

    // One packet: request at cycle 0, words fed on handshake, flits collected
    task automatic run_pkt(input logic [3:0] dx, input logic [3:0] dy,
                           input logic [3:0] len, input int nwords);
        int          widx;
        logic [33:0] prev_flit;
        bit          prev_stall;
        bit          fin;
        widx = 0; n_got = 0; n_stall = 0; n_hold_err = 0; n_dr_err = 0; n_rr_err = 0;
        fin = 1'b0; prev_stall = 1'b0; prev_flit = '0;
        for (int c = 0; c < 40 && !fin; c++) begin
            if (c == rst_at) begin
                req_valid = 1'b0; data_valid = 1'b0; noc_rst_n = 1'b0;
                #1;
                check("rst_mid_out_valid", out_valid, 0);
                check("rst_mid_out_flit", out_flit, 0);
                check("rst_mid_out_vc", out_vc, 0);
                check("rst_mid_pkt_count", pkt_count, 0);
                check("rst_mid_data_ready", data_ready, 0);
                exp_pkts = 16'd0;
                @(negedge noc_clk);
                noc_rst_n = 1'b1;
                return;
            end
            out_ready  = rdy_pat[c];
            req_valid  = (c == 0);
            req_dst_x  = dx; req_dst_y = dy; req_len = len;
            data_valid = (widx < nwords);
            data       = wq[widx & 7];
            #1;
            if (c == 0) check("req_ready_idle", req_ready, 1);
            else if (req_ready) n_rr_err++;
            if (data_valid && data_ready) widx++;
            if (out_valid && out_ready[out_vc]) begin
                if (n_got < 16) begin
                    got_flit[n_got] = out_flit; got_vc[n_got] = out_vc; got_cyc[n_got] = c;
                end
                n_got++;
                if (out_flit[33]) fin = 1'b1;
                prev_stall = 1'b0;
            end else if (out_valid) begin
                n_stall++;
                if (prev_stall && out_flit != prev_flit) n_hold_err++;
                if (data_ready) n_dr_err++;
                prev_stall = 1'b1; prev_flit = out_flit;
            end else begin
                prev_stall = 1'b0;
            end
            @(negedge noc_clk);
        end
        check("pkt_complete", fin, 1);
        check("req_ready_busy", n_rr_err, 0);
        if (fin) exp_pkts = exp_pkts + 16'd1;
        data_valid = 1'b0;
        out_ready  = 2'b11;
    endtask

    initial begin
        noc_rst_n = 1'b0; id_x = 4'd1; id_y = 4'd2;
        req_valid = 1'b0; req_dst_x = 4'd0; req_dst_y = 4'd0; req_len = 4'd0;
        data_valid = 1'b0; data = 32'd0; out_ready = 2'b11;
        rst_at = -1; exp_pkts = 16'd0;
        set_rdy(0, 63, 2'b11);
        repeat (2) @(negedge noc_clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_flit", out_flit, 0);
        check("reset_out_vc", out_vc, 0);
        check("reset_pkt_count", pkt_count, 0);
        check("reset_data_ready", data_ready, 0);
        noc_rst_n = 1'b1;
        @(negedge noc_clk);

        // Single head+tail flit: dst(3,0) src(1,2) len 0
        run_pkt(4'd3, 4'd0, 4'd0, 0);
        check("s1_n_flits", n_got, 1);
        check("s1_flit", got_flit[0], 34'h3_0000_2103);
        check("s1_vc", got_vc[0], 0);
        check("s1_latency", got_cyc[0], 2);
        check("s1_pkt_count", pkt_count, exp_pkts);
        check("s1_req_ready_after", req_ready, 1);

        // len 3 back-to-back under continuous credit
        wq[0] = 32'hA; wq[1] = 32'hB; wq[2] = 32'hC;
        run_pkt(4'd3, 4'd0, 4'd3, 3);
        check("s2_n_flits", n_got, 4);
        check("s2_head", got_flit[0], 34'h1_0003_2103);
        check("s2_body0", got_flit[1], 34'h0_0000_000A);
        check("s2_body1", got_flit[2], 34'h0_0000_000B);
        check("s2_tail", got_flit[3], 34'h2_0000_000C);
        for (int i = 0; i < 4; i++) check("s2_cycle", got_cyc[i], 2 + i);
        check("s2_pkt_count", pkt_count, exp_pkts);

        // Only VC1 has credit at head; VC0 appears later and must be ignored
        set_rdy(0, 2, 2'b10); set_rdy(3, 63, 2'b11);
        wq[0] = 32'h11; wq[1] = 32'h22;
        run_pkt(4'd3, 4'd0, 4'd2, 2);
        check("s3_n_flits", n_got, 3);
        for (int i = 0; i < 3; i++) check("s3_vc", got_vc[i], 1);
        check("s3_head", got_flit[0], 34'h1_0002_2103);
        check("s3_body", got_flit[1], 34'h0_0000_0011);
        check("s3_tail", got_flit[2], 34'h2_0000_0022);

        // Credit withdrawn for 5 cycles while the head is waiting
        set_rdy(0, 1, 2'b11); set_rdy(2, 6, 2'b00); set_rdy(7, 63, 2'b11);
        wq[0] = 32'h33; wq[1] = 32'h44;
        run_pkt(4'd3, 4'd0, 4'd2, 2);
        check("s4_n_flits", n_got, 3);
        check("s4_stall_cycles", n_stall, 5);
        check("s4_flit_held", n_hold_err, 0);
        check("s4_data_ready_low", n_dr_err, 0);
        check("s4_head", got_flit[0], 34'h1_0002_2103);
        check("s4_head_cycle", got_cyc[0], 7);
        check("s4_body", got_flit[1], 34'h0_0000_0033);
        check("s4_tail", got_flit[2], 34'h2_0000_0044);
        set_rdy(0, 63, 2'b11);

        // Reset after the first body flit, then a fresh len 1 packet
        wq[0] = 32'hA; wq[1] = 32'hB; wq[2] = 32'hC;
        rst_at = 4;
        run_pkt(4'd3, 4'd0, 4'd3, 3);
        rst_at = -1;
        check("s5_flits_before_rst", n_got, 2);
        check("s5_body_before_rst", got_flit[1], 34'h0_0000_000A);
        @(negedge noc_clk);
        check("s5_idle_after_rst", out_valid, 0);
        wq[0] = 32'h55;
        run_pkt(4'd2, 4'd1, 4'd1, 1);
        check("s5_n_flits", n_got, 2);
        check("s5_head", got_flit[0], 34'h1_0001_2112);
        check("s5_tail", got_flit[1], 34'h2_0000_0055);
        check("s5_tail_cycle", got_cyc[1], 3);
        check("s5_pkt_count", pkt_count, 1);

        // Counter wrap: preload near the top, then three single-flit packets
        force dut.r_pkt_count = 16'hFFFE;
        @(negedge noc_clk);
        release dut.r_pkt_count;
        exp_pkts = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            run_pkt(4'd3, 4'd0, 4'd0, 0);
            check("s6_pkt_count", pkt_count, exp_pkts);
        end
        check("s6_wrapped_to_1", pkt_count, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_packet_injector.md
NOC_PACKET_INJECTOR -- requirements
Module: noc_packet_injector

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the payload bits per flit.
REQ-002 SHALL have parameter CHANNELS, default Noc_VC_Channel, meaning the number of virtual channels toward the router local port.
REQ-003 SHALL have parameter LEN_W, default 4, meaning the width of the packet payload-length field.
REQ-004 SHALL have port noc_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port noc_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have ports id_x / id_y, input, Noc_ID_X_Width / Noc_ID_Y_Width bits: own node coordinates.
REQ-007 SHALL have ports req_valid (in, 1), req_ready (out, 1), req_dst_x (in, Noc_ID_X_Width), req_dst_y (in, Noc_ID_Y_Width), req_len (in, LEN_W): the packet request channel.
REQ-008 SHALL have ports data_valid (in, 1), data_ready (out, 1), data (in, DATA_W): the payload word stream.
REQ-009 SHALL have ports out_valid (out, 1), out_vc (out, $clog2(CHANNELS)), out_flit (out, DATA_W+2), out_ready (in, CHANNELS): flit toward the router local receiver; out_ready holds per-VC credit.
REQ-010 SHALL have port pkt_count, output, 16 bits: count of completed packets.

Function
REQ-011 SHALL place the flit type in out_flit[DATA_W+1:DATA_W]: 01 head, 00 body, 10 tail, 11 head+tail.
REQ-012 SHALL pack the head payload LSB-first as {len, src_y, src_x, dst_y, dst_x}, zero-padded; elaboration SHALL fail if DATA_W < 2*(Noc_ID_X_Width+Noc_ID_Y_Width)+LEN_W.
REQ-013 SHALL transfer a flit only in a cycle with out_valid && out_ready[out_vc].
REQ-014 SHALL hold out_valid, out_vc and out_flit stable until that transfer.
REQ-015 SHALL use FSM states IDLE, HEAD, BODY.
REQ-016 In IDLE, SHALL assert req_ready; on req_valid it SHALL latch dst, len and src, then go to HEAD.
REQ-017 In HEAD, SHALL select the lowest-indexed VC with out_ready high in the first cycle of HEAD, register it, and keep that VC for the whole packet.
REQ-018 SHALL assert out_valid with the head flit one cycle after VC selection; head-to-valid latency from request acceptance is 2 cycles.
REQ-019 If no VC is ready in HEAD, SHALL wait in HEAD with out_valid low.
REQ-020 For len==0, SHALL send one head+tail flit and return to IDLE.
REQ-021 For len>0, SHALL go from HEAD to BODY and send len payload flits, the last typed tail, using a down-counter loaded with len.
REQ-022 In BODY, SHALL assert data_ready only when the output register is empty or transferring this cycle, so data_valid && data_ready loads the next flit with no bubble under continuous credit.
REQ-023 Between payload words, SHALL deassert out_valid when data_valid is low; this SHALL NOT abort the packet.
REQ-024 SHALL NOT change VC mid-packet when out_ready of the locked VC drops; it SHALL stall.
REQ-025 On tail transfer, SHALL return to IDLE and increment pkt_count, with wrap from 16'hFFFF to 0.
REQ-026 SHALL accept the next req_valid in the cycle after tail transfer at the earliest.
REQ-027 SHALL keep req_ready low outside IDLE and data_ready low outside BODY.

Reset
REQ-028 While noc_rst_n is low, SHALL force state IDLE, out_valid 0, out_vc 0, out_flit 0, pkt_count 0, counter 0 and latched request 0.
REQ-029 SHALL drop any packet in flight when reset is asserted mid-packet, with no tail emitted.

Structure
REQ-030 SHALL place the flit-type enum (HEAD, BODY, TAIL, HEAD_TAIL) and the head-field offsets in Noc_parameters.
REQ-031 SHALL implement VC selection as one sub-module, noc_vc_lowest_select: a combinational priority encoder with a found flag.

Verification
REQ-032 Scenario: id(1,2), request dst(3,0) len=0, out_ready=2'b11 -> one flit, type 11, dst 3/0, src 1/2, out_vc=0; pkt_count=1.
REQ-033 Scenario: len=3, data 0xA,0xB,0xC back-to-back, credit always on -> flit types 01,00,00,10 on 4 consecutive cycles, payloads in order.
REQ-034 Scenario: out_ready=2'b10 at head -> out_vc=1 for all flits; raising out_ready[0] mid-packet does not move the VC.
REQ-035 Scenario: len=2, out_ready[out_vc] low for 5 cycles after the head -> out_flit held stable, data_ready low, no word lost.
REQ-036 Scenario: noc_rst_n pulsed low after the first body flit -> outputs zero immediately; a new len=1 packet afterwards is correct.
REQ-037 Scenario: 65537 single-flit packets -> pkt_count reads 1.
